image_loader: RTL

Upstream feeder for `simpleCNN`. It accepts a row-major 8-bit pixel stream over a valid/ready handshake and assembles 25 pixels into the 200-bit `IMGIN` frame. It then presents the frame and issues a one-cycle `START` to `simpleCNN`, and tracks `DONE` so a new frame is only launched when the CNN is idle. A shadow buffer lets the next frame load while the CNN is still computing.

---
 rtl/cnn_pkg.sv | 16 +
 rtl/pix_shadow_buf.sv | 43 ++++
 rtl/image_loader.sv | 117 +++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Constants and loader state type shared by image_loader, simpleCNN and their benches.
// A frame is 25 row-major 8-bit pixels packed with pixel k at bits [8k+7:8k].
package cnn_pkg;

  localparam int PIX_W = 8;
  localparam int N_PIX = 25;
  localparam int IMG_W = PIX_W * N_PIX;
  localparam int CNT_W = $clog2(N_PIX);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } loader_state_e;

endpackage

// File: rtl/pix_shadow_buf.sv
// 25x8 pixel register file that collects the frame being loaded.
// One write port addressed by the pixel slot, whole frame readable as a flat vector.
module pix_shadow_buf
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic [IMG_W-1:0] rd_flat
);

  logic [PIX_W-1:0] mem_q [N_PIX];
  logic [PIX_W-1:0] mem_d [N_PIX];

  // Address compare per slot keeps out-of-range counts from writing anything.
  always_comb begin
    for (int i = 0; i < N_PIX; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_addr == CNT_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PIX; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_PIX; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  for (genvar g = 0; g < N_PIX; g++) begin : g_flat
    assign rd_flat[g*PIX_W +: PIX_W] = mem_q[g];
  end

endmodule

// File: rtl/image_loader.sv
// Assembles a 25-pixel stream into one IMGIN frame and launches simpleCNN with START.
// A shadow buffer lets the next frame load while IMGIN stays frozen for the running CNN.
module image_loader
  import cnn_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic [PIX_W-1:0] PIX_IN,
  input  logic             PIX_VALID,
  input  logic             PIX_LAST,
  output logic             PIX_READY,
  output logic [IMG_W-1:0] IMGIN,
  output logic             START,
  input  logic             DONE,
  output logic             CNN_BUSY,
  output logic             ERR
);

  loader_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IMG_W-1:0] imgin_q, imgin_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic             beat;
  logic             at_end;
  logic             shadow_we;
  logic [IMG_W-1:0] shadow_flat;

  pix_shadow_buf u_shadow (
    .clk     (CLK),
    .rst_n   (nRST),
    .wr_en   (shadow_we),
    .wr_addr (cnt_q),
    .wr_data (PIX_IN),
    .rd_flat (shadow_flat)
  );

  // Ready depends on state only, so upstream never sees a VALID->READY loop.
  assign PIX_READY = (state_q != HOLD);
  assign beat      = PIX_VALID && PIX_READY;
  assign at_end    = (cnt_q == CNT_W'(N_PIX - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    imgin_d   = imgin_q;
    start_d   = 1'b0;
    err_d     = 1'b0;
    shadow_we = 1'b0;
    // START wins over DONE so a same-cycle pair keeps the CNN marked busy.
    busy_d    = start_q ? 1'b1 : (DONE ? 1'b0 : busy_q);

    case (state_q)
      LOAD: begin
        if (beat) begin
          shadow_we = 1'b1;
          if (at_end && PIX_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else if (PIX_LAST) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else if (at_end) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = DROP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (!busy_q || DONE) begin
          imgin_d = shadow_flat;
          start_d = 1'b1;
          state_d = LOAD;
        end
      end
      DROP: begin
        if (beat && PIX_LAST) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      imgin_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      imgin_q <= imgin_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign IMGIN    = imgin_q;
  assign START    = start_q;
  assign CNN_BUSY = busy_q;
  assign ERR      = err_q;

endmodule
